display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexes one shared BCD-to-7-segment decoder across a 4-digit common-anode display. Holds a 4-digit BCD value and presents one digit nibble per slot to the decoder inputs. Drives active-low digit enables and inserts an all-off guard interval between digits to prevent ghosting. New values are accepted over a valid/ready handshake and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DWELL, 50000, clock cycles each digit is lit per slot (>=1)
BLANK_CYC, 500, clock cycles all digits are off after each dwell (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_value  in  16  four BCD digits; [15:12] most significant (digit 3), [3:0] digit 0
in_valid  in  1  in_value offered
in_ready  out  1  controller can accept a value
lz_en  in  1  leading-zero suppression enable; sampled live
bcd_out  out  4  nibble to shared decoder W,X,Y,Z (W = bit 3); 4'hF = blank
an_n  out  4  digit enables, active low, an_n[i] lights digit i
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- All outputs are registered. Reset (async, rst_n=0): an_n=4'b1111, bcd_out=4'hF, in_ready=1, frame_tick=0. Active and pending registers are cleared to 16'h0000, digit index=0, state=SHOW, timer=0.
- States:
  - SHOW: an_n has bit idx low. bcd_out = active digit idx, or 4'hF if suppressed. Lasts DWELL cycles, then BLANK.
  - BLANK: an_n=4'b1111, bcd_out=4'hF. Lasts BLANK_CYC cycles. Then idx wraps 3->0 and the state returns to SHOW.
- The first rising edge after reset release shows digit 0.
- Frame = 4*(DWELL+BLANK_CYC) cycles.
- Frame boundary is the last BLANK cycle of idx=3. frame_tick=1 on the following cycle, coincident with the first SHOW cycle of digit 0.
- Handshake:
  - A transfer occurs when in_valid and in_ready are both high on a clock edge.
  - Off-boundary transfer: in_value goes to pending, and in_ready=0 from the next cycle.
  - At the boundary with a pending value held: pending is copied to active, and in_ready returns to 1 in the next cycle.
  - Transfer on the boundary cycle itself with nothing pending: in_value goes directly to active, and in_ready stays 1.
  - in_value is not required to stay stable after the transfer.
- Leading-zero suppression (lz_en=1):
  - Digit i (i=3..1) is blanked when active digits 3..i are all zero.
  - Digit 0 is never suppressed, so value 0000 shows "0".
  - With lz_en=0, all digits are shown.
- Nibbles >9 are passed through unchanged. The decoder blanks them; this block does not check them.
- Timer width is $clog2(max(DWELL,BLANK_CYC)). The timer counts 0..N-1 and clears on every state change.
- Reset asserted mid-frame takes effect immediately (async). A pending value is discarded.
- an_n never has more than one bit low. Every transition from one digit to the next passes through at least one all-ones cycle.

Decomposition:
- Package display_pkg:
  - state enum {SHOW, BLANK}
  - NDIG=4
  - BCD_BLANK=4'hF
  - AN_OFF=4'b1111
- The decoder (BCD to segments) is instantiated beside this block in the parent, not inside it.
- No sub-module is needed. The dwell/blank timer is local to this block.

Test Plan (DWELL=4, BLANK_CYC=2, frame=24 cycles):
- Reset then release, no load -> an_n sequence 1110 x4, 1111 x2, 1101 x4, 1111 x2, ..., bcd_out=0 during SHOW; frame_tick pulses every 24 cycles.
- Load 16'h1234 mid-frame with lz_en=0 -> in_ready low until boundary; next frame bcd_out shows 4,3,2,1 while an_n=1110,1101,1011,0111; in_ready high after boundary.
- Load 16'h0042 with lz_en=1 -> digits 3,2 give bcd_out=F, digit 1 gives 4, digit 0 gives 2; load 16'h0000 -> only digit 0 shows 0.
- Assert in_valid on the boundary cycle with nothing pending (value 16'h9876) -> shown starting in the immediately following frame; in_ready never drops.
- Second in_valid while in_ready=0 (first 16'h1111, then 16'h2222) -> 2222 is not captured; 1111 is displayed; 2222 is accepted after in_ready rises.
- Assert rst_n=0 mid-SHOW of digit 2 with a pending value -> an_n=1111 and bcd_out=F immediately; after release, digit 0 shows 0 (pending value lost), in_ready=1.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Brief    : Shared types and constants for the multiplexed display scanner
//  Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Scan phase: a digit is lit (SHOW) or all digits are dark (BLANK)
    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    localparam int         NDIG      = 4;
    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Width of a counter that must hold 0..max(a,b)-1; never narrower than 1 bit
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

    // Leading-zero test: digit idx is dark when it and every higher digit are
    // zero; digit 0 always shows so a zero value still reads "0"
    function automatic logic lz_suppress(input logic [15:0] value, input logic [1:0] idx);
        logic nonzero;
        nonzero = 1'b0;
        for (int i = 1; i < NDIG; i++) begin
            if (i >= int'(idx) && value[4*i +: 4] != 4'h0) begin
                nonzero = 1'b1;
            end
        end
        return (idx != 2'd0) && !nonzero;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_ctrl
//  Brief    : Scans a 4-digit BCD value onto a common-anode display through a
//             shared decoder, with guard blanking between digits and
//             frame-aligned value updates over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DWELL     = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_value,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        lz_en,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int            c_tw         = timer_width(DWELL, BLANK_CYC);
    localparam logic [c_tw-1:0] c_dwell_last = c_tw'(DWELL - 1);
    localparam logic [c_tw-1:0] c_blank_last = c_tw'(BLANK_CYC - 1);

    // Scan position registers describe the cycle that the next edge will
    // present on the outputs, so every output can be registered directly.
    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_nxt;
    logic [c_tw-1:0]   r_timer;
    logic [c_tw-1:0]   w_timer_nxt;
    logic              r_started;

    logic [15:0]       r_active;
    logic [15:0]       r_pending;
    logic [15:0]       w_active_nxt;
    logic              r_ready;

    logic [3:0]        r_an_n;
    logic [3:0]        r_bcd;
    logic              r_tick;

    logic              w_boundary;
    logic              w_xfer;
    logic [3:0]        w_digit;
    logic [3:0]        w_an_show;

    // The edge that closes the last BLANK cycle of digit 3; the very first
    // edge after reset has the same scan position but is not a boundary.
    assign w_boundary = r_started && (r_state == SHOW) && (r_idx == 2'd0) && (r_timer == '0);
    assign w_xfer     = in_valid && r_ready;

    // Scan position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SHOW;
            r_idx     <= 2'd0;
            r_timer   <= '0;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_timer   <= w_timer_nxt;
            r_started <= 1'b1;
        end
    end

    // Next scan position: dwell, then blank, then advance to the next digit
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer + 1'b1;
        case (r_state)
            SHOW: begin
                if (r_timer == c_dwell_last) begin
                    w_state_nxt = BLANK;
                    w_timer_nxt = '0;
                end
            end
            BLANK: begin
                if (r_timer == c_blank_last) begin
                    w_state_nxt = SHOW;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = SHOW;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Value shown from the next cycle on; only changes at a frame boundary,
    // a held pending value takes priority over a same-edge offer
    always_comb begin
        w_active_nxt = r_active;
        if (w_boundary) begin
            if (!r_ready) begin
                w_active_nxt = r_pending;
            end else if (in_valid) begin
                w_active_nxt = in_value;
            end
        end
    end

    // Handshake: off-boundary offers park in pending and close in_ready until
    // the boundary has consumed them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 16'h0000;
            r_pending <= 16'h0000;
            r_ready   <= 1'b1;
        end else begin
            r_active <= w_active_nxt;
            if (w_boundary) begin
                r_ready <= 1'b1;
            end else if (w_xfer) begin
                r_pending <= in_value;
                r_ready   <= 1'b0;
            end
        end
    end

    assign w_digit   = w_active_nxt[{r_idx, 2'b00} +: 4];
    assign w_an_show = AN_OFF & ~(4'b0001 << r_idx);

    // Registered display outputs decoded from the upcoming scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n <= AN_OFF;
            r_bcd  <= BCD_BLANK;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_boundary;
            if (r_state == SHOW) begin
                r_an_n <= w_an_show;
                r_bcd  <= (lz_en && lz_suppress(w_active_nxt, r_idx)) ? BCD_BLANK : w_digit;
            end else begin
                r_an_n <= AN_OFF;
                r_bcd  <= BCD_BLANK;
            end
        end
    end

    assign an_n       = r_an_n;
    assign bcd_out    = r_bcd;
    assign frame_tick = r_tick;
    assign in_ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scan_ctrl
//  Brief    : Directed self-checking bench for display_scan_ctrl with
//             DWELL=4, BLANK_CYC=2 (24-cycle frames)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_value;
    logic        in_valid;
    logic        in_ready;
    logic        lz_en;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    // 10 time-unit clock
    always #5 clk = ~clk;

    display_scan_ctrl #(
        .DWELL     (4),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_value   (in_value),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lz_en      (lz_en),
        .bcd_out    (bcd_out),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 24-cycle frame. exp_digits holds the nibble expected on bcd_out for
    // each digit slot (digit i at [4i+3:4i]); rdy_mask bit c is the expected
    // in_ready in cycle c. After sampling cycle c, in_valid is dropped where
    // drop_mask is set and an offer is placed at ld_cyc / ld2_cyc.
    task automatic frame(input string name, input logic [15:0] exp_digits,
                         input bit tick_first, input logic [23:0] rdy_mask,
                         input int ld_cyc, input logic [15:0] ld_val,
                         input logic [23:0] drop_mask,
                         input int ld2_cyc, input logic [15:0] ld2_val);
        for (int c = 0; c < 24; c++) begin
            int         slot;
            int         pos;
            logic [3:0] e_an;
            logic [3:0] e_bcd;
            step();
            slot = c / 6;
            pos  = c % 6;
            if (pos < 4) begin
                e_an  = ~(4'b0001 << slot);
                e_bcd = exp_digits[4*slot +: 4];
            end else begin
                e_an  = 4'hF;
                e_bcd = 4'hF;
            end
            chk($sformatf("%s c%0d an_n", name, c), 16'(an_n), 16'(e_an));
            chk($sformatf("%s c%0d bcd_out", name, c), 16'(bcd_out), 16'(e_bcd));
            chk($sformatf("%s c%0d frame_tick", name, c), 16'(frame_tick),
                16'((c == 0) && tick_first));
            chk($sformatf("%s c%0d in_ready", name, c), 16'(in_ready), 16'(rdy_mask[c]));
            if (drop_mask[c]) in_valid = 1'b0;
            if (c == ld_cyc) begin
                in_value = ld_val;
                in_valid = 1'b1;
            end
            if (c == ld2_cyc) begin
                in_value = ld2_val;
                in_valid = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = 16'h0000;
        lz_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset an_n", 16'(an_n), 16'hF);
        chk("reset bcd_out", 16'(bcd_out), 16'hF);
        chk("reset in_ready", 16'(in_ready), 16'h1);
        chk("reset frame_tick", 16'(frame_tick), 16'h0);
        rst_n = 1'b1;

        // Idle frame shows 0000; 1234 offered mid-frame at cycle 7
        frame("f1_idle", 16'h0000, 1'b0, 24'h0000FF, 7, 16'h1234, 24'h000100, -1, 16'h0);
        // 1234 shown; 0042 offered at cycle 3
        frame("f2_1234", 16'h1234, 1'b1, 24'h00000F, 3, 16'h0042, 24'h000010, -1, 16'h0);
        lz_en = 1'b1;
        // 0042 with suppression; 0000 offered at cycle 10
        frame("f3_0042", 16'hFF42, 1'b1, 24'h0007FF, 10, 16'h0000, 24'h000800, -1, 16'h0);
        // 0000 shows only digit 0; 9876 offered on the boundary cycle
        frame("f4_0000", 16'hFFF0, 1'b1, 24'hFFFFFF, 23, 16'h9876, 24'h000000, -1, 16'h0);
        // 9876 shown at once; 1111 offered at 2, then 2222 held from 8
        frame("f5_9876", 16'h9876, 1'b1, 24'h000007, 2, 16'h1111, 24'h000009, 8, 16'h2222);
        // 1111 shown; held 2222 taken right after in_ready returns
        frame("f6_1111", 16'h1111, 1'b1, 24'h000001, -1, 16'h0, 24'h000002, -1, 16'h0);
        // 2222 shown; 5555 offered at cycle 5
        frame("f7_2222", 16'h2222, 1'b1, 24'h00003F, 5, 16'h5555, 24'h000040, -1, 16'h0);

        // Partial frame: 5555 active, 7777 left pending, reset during digit 2
        repeat (4) step();
        in_value = 16'h7777;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("f8 pending in_ready", 16'(in_ready), 16'h0);
        repeat (8) step();
        chk("f8 digit2 an_n", 16'(an_n), 16'hB);
        chk("f8 digit2 bcd_out", 16'(bcd_out), 16'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset an_n", 16'(an_n), 16'hF);
        chk("async reset bcd_out", 16'(bcd_out), 16'hF);
        chk("async reset in_ready", 16'(in_ready), 16'h1);
        chk("async reset frame_tick", 16'(frame_tick), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Pending 7777 discarded: value 0000 with suppression
        frame("f9_post_reset", 16'hFFF0, 1'b0, 24'hFFFFFF, -1, 16'h0, 24'h000000, -1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
